// File: rtl/i2c_bit_master.sv
// Byte-level I2C master sequencer. It steps through START, address, data, ACK and STOP
// on the data_clk phase clock, and it drives SDA as an open-drain pull-down enable.
module i2c_bit_master (
    input  logic       clk,
    input  logic       rst,
    input  logic       data_clk,
    input  logic       ena,
    input  logic [6:0] addr,
    input  logic       rw,
    input  logic [7:0] data_wr,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic       scl_not_ena,
    output logic       busy,
    output logic       done,
    output logic [7:0] data_rd,
    output logic       ack_error
);

    typedef enum logic [3:0] {
        ST_READY    = 4'd0,
        ST_START    = 4'd1,
        ST_ADDR     = 4'd2,
        ST_SLV_ACK1 = 4'd3,
        ST_WR       = 4'd4,
        ST_RD       = 4'd5,
        ST_SLV_ACK2 = 4'd6,
        ST_MSTR_ACK = 4'd7,
        ST_STOP     = 4'd8
    } state_t;

    state_t     state_r, state_s;
    logic [2:0] bit_cnt_r, bit_cnt_s;
    logic [7:0] addr_rw_r, addr_rw_s;
    logic [7:0] data_tx_r, data_tx_s;
    logic [7:0] data_rx_r, data_rx_s;
    logic [7:0] data_rd_r, data_rd_s;
    logic       sda_oe_r, sda_oe_s;
    logic       scl_not_ena_r, scl_not_ena_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       ack_error_r, ack_error_s;
    logic       cont_r, cont_s;
    logic       dc_q_r;
    logic       rise_s, fall_s, same_cmd_s;

    assign rise_s     = data_clk & ~dc_q_r;
    assign fall_s     = ~data_clk & dc_q_r;
    // A continuation needs the same target and direction as the byte in flight
    assign same_cmd_s = ena & ({addr, rw} == addr_rw_r);

    // Next-state and output decode; nothing moves except on a data_clk edge
    always_comb begin
        state_s       = state_r;
        bit_cnt_s     = bit_cnt_r;
        addr_rw_s     = addr_rw_r;
        data_tx_s     = data_tx_r;
        data_rx_s     = data_rx_r;
        data_rd_s     = data_rd_r;
        sda_oe_s      = sda_oe_r;
        scl_not_ena_s = scl_not_ena_r;
        busy_s        = busy_r;
        done_s        = 1'b0;
        ack_error_s   = ack_error_r;
        cont_s        = cont_r;
        if (rise_s) begin
            case (state_r)
                ST_READY: begin
                    if (ena) begin
                        addr_rw_s = {addr, rw};
                        data_tx_s = data_wr;
                        busy_s    = 1'b1;
                        state_s   = ST_START;
                    end else begin
                        state_s = ST_READY;
                    end
                end
                ST_START: begin
                    bit_cnt_s = 3'd7;
                    state_s   = ST_ADDR;
                end
                ST_ADDR: begin
                    if (bit_cnt_r == 3'd0) begin
                        state_s = ST_SLV_ACK1;
                    end else begin
                        bit_cnt_s = bit_cnt_r - 3'd1;
                    end
                end
                ST_SLV_ACK1: begin
                    bit_cnt_s = 3'd7;
                    state_s   = addr_rw_r[0] ? ST_RD : ST_WR;
                end
                ST_WR: begin
                    if (bit_cnt_r == 3'd0) begin
                        state_s = ST_SLV_ACK2;
                    end else begin
                        bit_cnt_s = bit_cnt_r - 3'd1;
                    end
                end
                ST_RD: begin
                    if (bit_cnt_r == 3'd0) begin
                        done_s    = 1'b1;
                        data_rd_s = data_rx_r;
                        cont_s    = same_cmd_s;
                        state_s   = ST_MSTR_ACK;
                    end else begin
                        bit_cnt_s = bit_cnt_r - 3'd1;
                    end
                end
                ST_SLV_ACK2: begin
                    done_s = 1'b1;
                    if (same_cmd_s) begin
                        data_tx_s = data_wr;
                        bit_cnt_s = 3'd7;
                        state_s   = ST_WR;
                    end else if (ena) begin
                        addr_rw_s = {addr, rw};
                        state_s   = ST_START;
                    end else begin
                        state_s = ST_STOP;
                    end
                end
                ST_MSTR_ACK: begin
                    if (cont_r) begin
                        bit_cnt_s = 3'd7;
                        state_s   = ST_RD;
                    end else if (ena) begin
                        addr_rw_s = {addr, rw};
                        state_s   = ST_START;
                    end else begin
                        state_s = ST_STOP;
                    end
                end
                ST_STOP: begin
                    busy_s  = 1'b0;
                    state_s = ST_READY;
                end
                default: begin
                    state_s = ST_READY;
                end
            endcase
            // The SDA level belongs to the state being entered and the bit it will present
            case (state_s)
                ST_START:    sda_oe_s = 1'b1;
                ST_STOP:     sda_oe_s = 1'b1;
                ST_ADDR:     sda_oe_s = ~addr_rw_s[bit_cnt_s];
                ST_WR:       sda_oe_s = ~data_tx_s[bit_cnt_s];
                ST_MSTR_ACK: sda_oe_s = cont_s;
                default:     sda_oe_s = 1'b0;
            endcase
        end else if (fall_s) begin
            case (state_r)
                ST_START: begin
                    scl_not_ena_s = 1'b0;
                    ack_error_s   = 1'b0;
                end
                ST_SLV_ACK1, ST_SLV_ACK2: begin
                    if (sda_in) begin
                        ack_error_s = 1'b1;
                    end else begin
                        ack_error_s = ack_error_r;
                    end
                end
                ST_RD: begin
                    data_rx_s[bit_cnt_r] = sda_in;
                end
                ST_STOP: begin
                    scl_not_ena_s = 1'b1;
                end
                default: begin
                    ack_error_s = ack_error_r;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // data_clk history for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dc_q_r <= 1'b0;
        end else begin
            dc_q_r <= data_clk;
        end
    end

    // Sequencer state, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ST_READY;
            bit_cnt_r     <= 3'd0;
            addr_rw_r     <= 8'd0;
            data_tx_r     <= 8'd0;
            data_rx_r     <= 8'd0;
            data_rd_r     <= 8'd0;
            sda_oe_r      <= 1'b0;
            scl_not_ena_r <= 1'b1;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
            ack_error_r   <= 1'b0;
            cont_r        <= 1'b0;
        end else begin
            state_r       <= state_s;
            bit_cnt_r     <= bit_cnt_s;
            addr_rw_r     <= addr_rw_s;
            data_tx_r     <= data_tx_s;
            data_rx_r     <= data_rx_s;
            data_rd_r     <= data_rd_s;
            sda_oe_r      <= sda_oe_s;
            scl_not_ena_r <= scl_not_ena_s;
            busy_r        <= busy_s;
            done_r        <= done_s;
            ack_error_r   <= ack_error_s;
            cont_r        <= cont_s;
        end
    end

    assign sda_oe      = sda_oe_r;
    assign scl_not_ena = scl_not_ena_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign data_rd     = data_rd_r;
    assign ack_error   = ack_error_r;

endmodule
